muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand and HI/LO width; all behaviour below is stated for WIDTH=32.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, begin operation; honoured only in IDLE.
REQ-005 SHALL have port op, input, 2, operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port rs_data, input, 32, operand A or dividend, driven from register-file readdata1.
REQ-007 SHALL have port rt_data, input, 32, operand B or divisor, driven from register-file readdata2.
REQ-008 SHALL have port mthi, input, 1, write rs_data to HI.
REQ-009 SHALL have port mtlo, input, 1, write rs_data to LO.
REQ-010 SHALL have port hi, output, 32, HI register, feeds the MFHI writeback path.
REQ-011 SHALL have port lo, output, 32, LO register, feeds the MFLO writeback path.
REQ-012 SHALL have port busy, output, 1, operation in progress; pipeline stalls MFHI/MFLO while high.
REQ-013 SHALL have port done, output, 1, one-cycle pulse marking new HI/LO.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE.
REQ-015 SHALL, in IDLE with start=1 at edge N, latch op, rs_data and rt_data, clear the step counter and enter RUN.
REQ-016 SHALL perform one shift-add (multiply) or one restoring-subtract (divide) step per RUN cycle, 32 steps total.
REQ-017 SHALL hold busy=1 after edge N through edge N+32, and busy=0 otherwise.
REQ-018 SHALL write HI/LO and enter DONE at edge N+32; done=1 for exactly one cycle; DONE returns to IDLE unconditionally at the next edge.
REQ-019 SHALL leave hi/lo unchanged during RUN; intermediate results are kept in internal registers only.
REQ-020 SHALL produce, for MULT/MULTU, the full 64-bit signed or unsigned product, with HI holding the upper 32 bits and LO the lower 32 bits.
REQ-021 SHALL produce, for DIV/DIVU, LO=quotient and HI=remainder.
REQ-022 SHALL, for signed divide, divide magnitudes; quotient is negated when operand signs differ, and the remainder takes the dividend's sign.
REQ-023 SHALL, on a zero divisor, still take 32 cycles and give LO=32'hFFFFFFFF and HI=dividend.
REQ-024 SHALL give DIV 32'h80000000 / 32'hFFFFFFFF the result LO=32'h80000000, HI=0.
REQ-025 SHALL ignore start in RUN and DONE, with no queuing.
REQ-026 SHALL, in IDLE, write HI on mthi and LO on mtlo at the edge; both may be asserted together; mthi/mtlo are ignored in RUN and DONE.
REQ-027 SHALL, when start and mthi/mtlo are asserted together in IDLE, accept start and drop the mt write.
REQ-028 SHALL ignore op values and operands except at the start edge.

Reset
REQ-029 SHALL, on rst=1, immediately force IDLE, hi=0, lo=0, busy=0, done=0 and clear internal registers, without waiting for clk.
REQ-030 SHALL abort any operation in progress on rst assertion mid-RUN, without updating HI/LO beyond the reset value.
REQ-031 SHALL accept start at the first rising edge after rst deasserts.

Structure
REQ-032 SHALL take op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the state enum from shared package muldiv_pkg.
REQ-033 SHALL place the single divide iteration (shift, trial subtract, quotient bit) in sub-module div_step; the multiply step stays inline.
REQ-034 SHALL use a 6-bit step counter and a 64-bit accumulator shared by multiply and divide.

Verification
REQ-035 SHALL verify: MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> after 32 busy cycles, HI=32'hFFFFFFFE, LO=32'h00000001, done pulse 1 cycle.
REQ-036 SHALL verify: MULT -3 x 7 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB; DIV -7 / 2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
REQ-037 SHALL verify: DIVU 100 / 0 -> LO=32'hFFFFFFFF, HI=100, latency unchanged; DIV 32'h80000000 / -1 -> LO=32'h80000000, HI=0.
REQ-038 SHALL verify: second start and mthi asserted mid-RUN are ignored; HI/LO reflect the first operation only.
REQ-039 SHALL verify: start+mtlo together in IDLE -> operation runs and LO ends as the operation result, not rs_data.
REQ-040 SHALL verify: rst pulsed at RUN step 10 -> busy=0, hi=lo=0 asynchronously; a new DIVU 10 / 3 then yields LO=3, HI=1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and small op-decode helpers.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic logic op_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on the packed {remainder, quotient} accumulator:
// shift left, trial-subtract the divisor, shift in the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // The remainder stays below the divisor, so the shifted value fits in
  // WIDTH+1 bits and the top bit of the difference is a clean borrow.
  assign rem_sh = acc_in[2*WIDTH-1:WIDTH-1];
  assign trial  = rem_sh - {1'b0, divisor};

  always_comb begin
    if (!trial[WIDTH]) acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
    else               acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32 shift-add or restoring
// steps on operand magnitudes, sign fix-up applied when HI/LO are written.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  state_e             state;
  logic [5:0]         cnt;
  logic               div_r, neg_q, neg_r, dz;
  logic [WIDTH-1:0]   b_r;
  logic [2*WIDTH-1:0] acc, acc_mul, acc_div, acc_nxt, prod;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem, hi_fin, lo_fin;
  logic [WIDTH:0]     psum;
  logic               sgn;

  assign sgn   = op_signed(op);
  assign a_mag = (sgn && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign b_mag = (sgn && rt_data[WIDTH-1]) ? -rt_data : rt_data;

  // Multiply: conditionally add multiplicand into the upper half, then shift right.
  assign psum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_r} : '0);
  assign acc_mul = {psum, acc[WIDTH-1:1]};

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .acc_in  (acc),
    .divisor (b_r),
    .acc_out (acc_div)
  );

  assign acc_nxt = div_r ? acc_div : acc_mul;
  assign prod    = neg_q ? -acc_nxt : acc_nxt;
  assign quo     = acc_nxt[WIDTH-1:0];
  assign rem     = acc_nxt[2*WIDTH-1:WIDTH];

  // Zero divisor leaves rem = |dividend|; restoring its sign yields the dividend.
  always_comb begin
    hi_fin = prod[2*WIDTH-1:WIDTH];
    lo_fin = prod[WIDTH-1:0];
    if (div_r) begin
      lo_fin = dz ? '1 : (neg_q ? -quo : quo);
      hi_fin = neg_r ? -rem : rem;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      div_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      b_r   <= '0;
      acc   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_r <= op_is_div(op);
            neg_q <= sgn && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_r <= sgn && rs_data[WIDTH-1];
            dz    <= op_is_div(op) && (rt_data == '0);
            b_r   <= b_mag;
            acc   <= {{WIDTH{1'b0}}, a_mag};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            if (mthi) hi <= rs_data;
            if (mtlo) lo <= rs_data;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 6'd1;
          if (cnt == LAST) begin
            hi    <= hi_fin;
            lo    <= lo_fin;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected {HI,LO}, a forked
// monitor pops on each done pulse and checks result, latency and HI/LO hold.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk, rst, start, mthi, mtlo, busy, done;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, hi, lo;
  logic [31:0] ref_hi, ref_lo;
  logic [63:0] exp_q[$];
  int          n_chk, n_pass;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference results straight from the arithmetic definitions.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     ia, ib;
    ia = a; ib = b; sa = ia; sb = ib;
    case (o)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(ia % ib), 32'(ia / ib)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic monitor();
    int          bcnt = 0;
    bit          hold_ok = 1'b1;
    bit          pd = 1'b0;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        bcnt = 0; hold_ok = 1'b1; pd = 1'b0;
      end else begin
        if (busy) begin
          bcnt++;
          if ({hi, lo} !== {ref_hi, ref_lo}) hold_ok = 1'b0;
        end
        if (pd) check("done_one_cycle", 64'(done), 64'd0);
        if (done) begin
          check("busy_cycles", 64'(bcnt), 64'd32);
          check("hilo_hold_in_run", 64'(hold_ok), 64'd1);
          if (exp_q.size() == 0) check("unexpected_done", 64'(done), 64'd0);
          else begin
            e = exp_q.pop_front();
            check("result_hilo", {hi, lo}, e);
          end
          bcnt = 0; hold_ok = 1'b1;
        end
        pd = done;
      end
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] e, input bit mtl);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b; mtlo = mtl;
    exp_q.push_back(e);
  endtask

  // Waits for IDLE; with poke, fires start+mthi mid-RUN and start during DONE.
  task automatic wait_idle(input bit poke);
    bit fin = 1'b0;
    for (int k = 0; k < 60 && !fin; k++) begin
      @(negedge clk);
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      if (!busy && !done) fin = 1'b1;
      else if (poke && (k == 5 || done)) begin
        start = 1'b1; mthi = 1'b1; op = 2'($urandom_range(0, 3));
        rs_data = $urandom; rt_data = $urandom;
      end
    end
    if (!fin) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] e, input bit poke, input bit mtl);
    issue(o, a, b, e, mtl);
    wait_idle(poke);
    {ref_hi, ref_lo} = e;
  endtask

  task automatic do_mt(input bit h, input bit l, input logic [31:0] v);
    @(negedge clk);
    mthi = h; mtlo = l; rs_data = v;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (h) ref_hi = v;
    if (l) ref_lo = v;
    check("mt_write", {hi, lo}, {ref_hi, ref_lo});
    check("mt_not_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    n_chk = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0; ref_hi = '0; ref_lo = '0;
    fork
      monitor();
    join_none

    #12;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    @(posedge clk); #2 rst = 1'b0;

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b0, 1'b0);
    do_op(OP_MULT, -32'sd3, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b0, 1'b0);
    do_op(OP_DIV, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 1'b0);
    do_op(OP_DIVU, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, 1'b0, 1'b0);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0, 1'b0);
    do_op(OP_DIV, -32'sd9, 32'd0, {-32'sd9, 32'hFFFF_FFFF}, 1'b0, 1'b0);

    do_mt(1'b1, 1'b0, 32'hA5A5_0001);
    do_mt(1'b0, 1'b1, 32'h5A5A_0002);
    do_mt(1'b1, 1'b1, 32'h1234_5678);

    // Second start and mthi during RUN/DONE must be ignored.
    do_op(OP_MULTU, 32'd1000, 32'd3000, {32'd0, 32'd3000000}, 1'b1, 1'b0);
    // start + mtlo together: op wins, LO is the quotient, not rs_data.
    do_op(OP_DIVU, 32'd1234, 32'd5, {32'd4, 32'd246}, 1'b0, 1'b1);

    do_mt(1'b1, 1'b1, 32'hDEAD_BEEF);
    issue(OP_DIVU, 32'd50, 32'd7, 64'd0, 1'b0);
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_hilo", {hi, lo}, 64'd0);
    check("async_rst_busy_done", {62'd0, busy, done}, 64'd0);
    exp_q.delete();
    ref_hi = '0; ref_lo = '0;
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    do_op(OP_DIVU, 32'd10, 32'd3, {32'd1, 32'd3}, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       begin a = $urandom; b = 32'd0; end
        1:       begin a = $urandom_range(0, 200); b = $urandom_range(1, 15); end
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      if ($urandom_range(0, 1) == 1) b = -b;
      do_op(o, a, b, model(o, a, b), i % 6 == 3, 1'b0);
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
